// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : eth_pkg                                                    |
// | Brief    : Shared MII receive constants, state encoding, CRC helpers  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ethernet_receive_data_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ethernet_receive_data_if                                   |
// | Brief    : MII receive pins plus frame-buffer write/status signals    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface ethernet_receive_data_if #(
    parameter int ADR_W = 11
);
    logic [3:0]       ETH_RX_DATA;
    logic             ETH_RX_DV;
    logic             ETH_RX_ER;
    logic [7:0]       data;
    logic [ADR_W-1:0] data_adr;
    logic             data_we;
    logic [ADR_W-1:0] frame_len;
    logic             finish;
    logic             error;

    modport master (
        input  ETH_RX_DATA, ETH_RX_DV, ETH_RX_ER,
        output data, data_adr, data_we, frame_len, finish, error
    );

    modport slave (
        output ETH_RX_DATA, ETH_RX_DV, ETH_RX_ER,
        input  data, data_adr, data_we, frame_len, finish, error
    );
endinterface
`default_nettype wire

// File: rtl/eth_crc32_nibble.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : eth_crc32_nibble                                           |
// | Brief    : Reflected CRC-32, one nibble per enabled cycle, LSB first  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module eth_crc32_nibble
    import eth_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    input  wire logic        en,
    input  wire logic [3:0]  nibble,
    output logic      [31:0] crc
);
    localparam logic [31:0] POLY_REFL = bit_reverse32(CRC32_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] step;

    always_comb begin
        crc_d = crc_q;
        step  = crc_q ^ {28'd0, nibble};
        if (clear) begin
            crc_d = CRC32_INIT;
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                step = step[0] ? ((step >> 1) ^ POLY_REFL) : (step >> 1);
            end
            crc_d = step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
endmodule
`default_nettype wire

// File: rtl/ethernet_receive_data.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ethernet_receive_data                                      |
// | Brief    : MII RX: strip preamble/SFD, pack nibbles, write buffer.    |
// |            Define MII_RX_CRC_CHECK_EN to flag frames with bad FCS.    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module ethernet_receive_data
    import eth_pkg::*;
#(
    parameter int ETH_FRAME_SIZE = 70,
    parameter int ADR_W          = 11
) (
    input  wire logic               ETH_RX_CLK,
    input  wire logic               rst,
    ethernet_receive_data_if.master rx
);
    localparam logic [ADR_W-1:0] FRAME_MAX = ADR_W'(ETH_FRAME_SIZE);

    rx_state_t        state_q, state_d;
    logic             phase_q, phase_d;        // 1 = waiting for high nibble
    logic [3:0]       low_nib_q, low_nib_d;
    logic [ADR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             sfd_seen_q, sfd_seen_d;
    logic [7:0]       data_q, data_d;
    logic [ADR_W-1:0] data_adr_q, data_adr_d;
    logic             data_we_q, data_we_d;
    logic [ADR_W-1:0] frame_len_q, frame_len_d;
    logic             finish_q, finish_d;
    logic             error_q, error_d;

    logic [3:0] nib;
    logic       dv;
    logic       er;
    logic       sfd_hit;
    logic       crc_bad;

    assign nib     = rx.ETH_RX_DATA;
    assign dv      = rx.ETH_RX_DV;
    assign er      = rx.ETH_RX_ER;
    assign sfd_hit = (state_q == ST_PREAMBLE) && dv && !er && (nib == SFD_NIBBLE);

`ifdef MII_RX_CRC_CHECK_EN
    logic [31:0] crc;

    eth_crc32_nibble u_crc (
        .clk    (ETH_RX_CLK),
        .rst    (rst),
        .clear  (sfd_hit),
        .en     ((state_q == ST_DATA) && dv && !er),
        .nibble (nib),
        .crc    (crc)
    );

    // The running register is LSB-first; the residue constant is MSB-first.
    assign crc_bad = (bit_reverse32(crc) != CRC32_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge ETH_RX_CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dv) begin
                    state_d = (nib == PREAMBLE_NIBBLE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!dv)                         state_d = ST_IDLE;
                else if (er)                     state_d = ST_DROP;
                else if (nib == SFD_NIBBLE)      state_d = ST_DATA;
                else if (nib != PREAMBLE_NIBBLE) state_d = ST_DROP;
            end
            ST_DATA: begin
                if (!dv)                                 state_d = ST_IDLE;
                else if (er)                             state_d = ST_DROP;
                else if (phase_q && byte_cnt_q == FRAME_MAX) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (!dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        low_nib_d   = low_nib_q;
        byte_cnt_d  = byte_cnt_q;
        sfd_seen_d  = sfd_seen_q;
        data_d      = data_q;
        data_adr_d  = data_adr_q;
        data_we_d   = 1'b0;
        frame_len_d = frame_len_q;
        finish_d    = 1'b0;
        error_d     = error_q;
        unique case (state_q)
            ST_IDLE: begin
                sfd_seen_d = 1'b0;
            end
            ST_PREAMBLE: begin
                if (sfd_hit) begin
                    sfd_seen_d = 1'b1;
                    error_d    = 1'b0;
                    byte_cnt_d = '0;
                    phase_d    = 1'b0;
                end
            end
            ST_DATA: begin
                if (!dv) begin
                    finish_d    = 1'b1;
                    frame_len_d = byte_cnt_q;
                    sfd_seen_d  = 1'b0;
                    if (phase_q || crc_bad) error_d = 1'b1;
                end else if (er) begin
                    error_d = 1'b1;
                end else if (!phase_q) begin
                    low_nib_d = nib;
                    phase_d   = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (byte_cnt_q == FRAME_MAX) begin
                        error_d = 1'b1;
                    end else begin
                        data_d     = {nib, low_nib_q};
                        data_adr_d = byte_cnt_q;
                        data_we_d  = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!dv) begin
                    sfd_seen_d = 1'b0;
                    if (sfd_seen_q) begin
                        finish_d    = 1'b1;
                        frame_len_d = byte_cnt_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ETH_RX_CLK or posedge rst) begin
        if (rst) begin
            phase_q     <= 1'b0;
            low_nib_q   <= '0;
            byte_cnt_q  <= '0;
            sfd_seen_q  <= 1'b0;
            data_q      <= '0;
            data_adr_q  <= '0;
            data_we_q   <= 1'b0;
            frame_len_q <= '0;
            finish_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            low_nib_q   <= low_nib_d;
            byte_cnt_q  <= byte_cnt_d;
            sfd_seen_q  <= sfd_seen_d;
            data_q      <= data_d;
            data_adr_q  <= data_adr_d;
            data_we_q   <= data_we_d;
            frame_len_q <= frame_len_d;
            finish_q    <= finish_d;
            error_q     <= error_d;
        end
    end

    assign rx.data      = data_q;
    assign rx.data_adr  = data_adr_q;
    assign rx.data_we   = data_we_q;
    assign rx.frame_len = frame_len_q;
    assign rx.finish    = finish_q;
    assign rx.error     = error_q;
endmodule
`default_nettype wire

// File: tb/tb_ethernet_receive_data.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ethernet_receive_data                                   |
// | Brief    : Directed MII frames, scoreboard of writes and finishes     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ethernet_receive_data;
    localparam int ADR_W = 11;
    localparam int FS    = 70;
`ifdef MII_RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ethernet_receive_data_if #(.ADR_W(ADR_W)) rx_if ();

    ethernet_receive_data #(
        .ETH_FRAME_SIZE (FS),
        .ADR_W          (ADR_W)
    ) dut (
        .ETH_RX_CLK (clk),
        .rst        (rst),
        .rx         (rx_if)
    );

    typedef struct packed { logic [ADR_W-1:0] adr; logic [7:0] d; } wr_t;
    typedef struct packed { logic [ADR_W-1:0] len; logic err; } fin_t;
    wr_t  wr_q[$];
    fin_t fin_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT write/finish against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.data_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got adr %0d data %0h required none",
                             rx_if.data_adr, rx_if.data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_adr", 32'(rx_if.data_adr), 32'(w.adr));
                    check("write_data", 32'(rx_if.data), 32'(w.d));
                end
            end
            if (rx_if.finish) begin
                if (fin_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_finish: got len %0d err %0d required none",
                             rx_if.frame_len, rx_if.error);
                end else begin
                    fin_t f;
                    f = fin_q.pop_front();
                    check("frame_len", 32'(rx_if.frame_len), 32'(f.len));
                    check("frame_error", 32'(rx_if.error), 32'(f.err));
                end
            end
        end
    end

    task automatic nib(input logic [3:0] d, input logic er = 1'b0);
        rx_if.ETH_RX_DATA = d;
        rx_if.ETH_RX_DV   = 1'b1;
        rx_if.ETH_RX_ER   = er;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_if.ETH_RX_DATA = 4'h0;
        rx_if.ETH_RX_DV   = 1'b0;
        rx_if.ETH_RX_ER   = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pre();
        repeat (15) nib(4'h5);
        nib(4'hD);
    endtask

    task automatic sbyte(input logic [7:0] b, input int adr, input logic expect_wr);
        nib(b[3:0]);
        if (expect_wr) wr_q.push_back('{adr: ADR_W'(adr), d: b});
        nib(b[7:4]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},      32'(rx_if.data), 32'h0);
        check({tag, "_data_adr"},  32'(rx_if.data_adr), 32'h0);
        check({tag, "_data_we"},   32'(rx_if.data_we), 32'h0);
        check({tag, "_frame_len"}, 32'(rx_if.frame_len), 32'h0);
        check({tag, "_finish"},    32'(rx_if.finish), 32'h0);
        check({tag, "_error"},     32'(rx_if.error), 32'h0);
    endtask

`ifdef MII_RX_CRC_CHECK_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic crc_frame(input logic flip);
        logic [7:0]  p[60];
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            p[i] = 8'(i * 7 + 1);
            c = crc_byte(c, p[i]);
        end
        fcs = ~c;
        if (flip) p[10] = p[10] ^ 8'h04;
        pre();
        for (int i = 0; i < 60; i++) sbyte(p[i], i, 1'b1);
        for (int i = 0; i < 4; i++) sbyte(fcs[8*i +: 8], 60 + i, 1'b1);
        fin_q.push_back('{len: ADR_W'(64), err: flip});
        idle(3);
    endtask
`endif

    initial begin
        rx_if.ETH_RX_DATA = 4'h0;
        rx_if.ETH_RX_DV   = 1'b0;
        rx_if.ETH_RX_ER   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        // Basic frame 12 34 AB
        pre();
        sbyte(8'h12, 0, 1'b1);
        sbyte(8'h34, 1, 1'b1);
        sbyte(8'hAB, 2, 1'b1);
        fin_q.push_back('{len: ADR_W'(3), err: CRC_ON});
        idle(3);

        // Broken preamble, DV held: must stay silent
        nib(4'h5); nib(4'h5); nib(4'h7);
        repeat (10) nib(4'h0);
        idle(3);

        // Overflow: 71 bytes, only 70 stored
        pre();
        for (int i = 0; i < 71; i++) sbyte(8'(i), i, i < FS);
        fin_q.push_back('{len: ADR_W'(FS), err: 1'b1});
        idle(3);

        // ER during byte index 5
        pre();
        for (int i = 0; i < 5; i++) sbyte(8'hA0 + 8'(i), i, 1'b1);
        nib(4'h1, 1'b1);
        nib(4'h2);
        nib(4'h3);
        fin_q.push_back('{len: ADR_W'(5), err: 1'b1});
        idle(3);

        // Odd nibble count
        pre();
        sbyte(8'hDE, 0, 1'b1);
        sbyte(8'hAD, 1, 1'b1);
        sbyte(8'hBE, 2, 1'b1);
        nib(4'h9);
        fin_q.push_back('{len: ADR_W'(3), err: 1'b1});
        idle(3);

        // Back-to-back frames separated by one idle cycle
        pre();
        sbyte(8'h5A, 0, 1'b1);
        fin_q.push_back('{len: ADR_W'(1), err: CRC_ON});
        idle(1);
        pre();
        sbyte(8'hC3, 0, 1'b1);
        fin_q.push_back('{len: ADR_W'(1), err: CRC_ON});
        idle(3);

        // Asynchronous reset mid-frame, remainder must be ignored
        pre();
        sbyte(8'h11, 0, 1'b1);
        sbyte(8'h22, 1, 1'b1);
        nib(4'h3);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) sbyte(8'h33, 0, 1'b0);
        idle(3);

`ifdef MII_RX_CRC_CHECK_EN
        crc_frame(1'b0);
        crc_frame(1'b1);
`endif

        idle(5);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        check("pending_finishes", 32'(fin_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
